// File: rtl/md_sched_pkg.sv
// Shared types for the mul/div issue scheduler: op encoding, FSM states and
// the per-lane request bundle.
package md_sched_pkg;

    localparam int XLEN         = 64;
    localparam int MD_ISSUE_NUM = 2;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } md_state_t;

    typedef struct packed {
        logic            valid;
        md_op_t          op;
        logic            word32;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } md_req_t;

endpackage

// File: rtl/md_pick.sv
// Fixed-priority pick of the lowest set bit: returns its index, a one-hot
// mask of it, and whether any bit was set.
module md_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_vec,
    output logic [IW-1:0] o_idx,
    output logic [N-1:0]  o_onehot,
    output logic          o_any
);

    logic [N-1:0] w_onehot;

    // Two's-complement trick isolates the lowest set bit.
    assign w_onehot = i_vec & (~i_vec + N'(1));

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (w_onehot[i]) begin
                o_idx = o_idx | IW'(i);
            end
        end
    end

    assign o_onehot = w_onehot;
    assign o_any    = |i_vec;

endmodule

// File: rtl/md_sched.sv
// Serialises mul/div requests from the issue lanes onto one shared iterative
// unit, buffers the per-lane results and stalls EX until the bundle retires.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int ISSUE_NUM = MD_ISSUE_NUM,
    parameter int MAX_LAT   = 80
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [ISSUE_NUM-1:0]      req_valid,
    input  logic [ISSUE_NUM*3-1:0]    req_op,
    input  logic [ISSUE_NUM-1:0]      req_word32,
    input  logic [ISSUE_NUM*XLEN-1:0] req_a,
    input  logic [ISSUE_NUM*XLEN-1:0] req_b,
    output logic                      md_start,
    output logic [2:0]                md_op,
    output logic                      md_word32,
    output logic [XLEN-1:0]           md_a,
    output logic [XLEN-1:0]           md_b,
    output logic                      md_abort,
    input  logic                      md_done,
    input  logic [XLEN-1:0]           md_res,
    output logic                      stall,
    output logic [ISSUE_NUM-1:0]      res_valid,
    output logic [ISSUE_NUM*XLEN-1:0] res,
    output logic                      wdog_err
);

    localparam int LW = (ISSUE_NUM > 1) ? $clog2(ISSUE_NUM) : 1;
    localparam int CW = $clog2(MAX_LAT + 1);

    md_state_t            r_state;
    logic [ISSUE_NUM-1:0] r_pending;
    logic [ISSUE_NUM-1:0] r_done_q;
    logic [LW-1:0]        r_lane_q;
    logic [ISSUE_NUM-1:0] r_lane_oh;
    logic [XLEN-1:0]      r_res_q [ISSUE_NUM];
    logic [CW-1:0]        r_wdog_cnt;
    logic                 r_wdog_err;

    md_req_t              w_lane [ISSUE_NUM];
    logic [ISSUE_NUM-1:0] w_req_vec;
    logic [ISSUE_NUM-1:0] w_remain;
    logic [LW-1:0]        w_req_idx;
    logic [LW-1:0]        w_next_idx;
    logic [ISSUE_NUM-1:0] w_req_oh;
    logic [ISSUE_NUM-1:0] w_next_oh;
    logic                 w_req_any;
    logic                 w_next_any;
    logic                 w_busy;

    generate
        for (genvar gi = 0; gi < ISSUE_NUM; gi++) begin : g_lane
            assign w_lane[gi] = md_req_t'({req_valid[gi], req_op[gi*3 +: 3], req_word32[gi],
                                           req_a[gi*XLEN +: XLEN], req_b[gi*XLEN +: XLEN]});
            assign w_req_vec[gi]           = w_lane[gi].valid;
            assign res[gi*XLEN +: XLEN]    = r_res_q[gi];
        end
    endgenerate

    assign w_remain = r_pending & ~r_lane_oh;

    md_pick #(.N(ISSUE_NUM), .IW(LW)) u_pick_req (
        .i_vec    (w_req_vec),
        .o_idx    (w_req_idx),
        .o_onehot (w_req_oh),
        .o_any    (w_req_any)
    );

    md_pick #(.N(ISSUE_NUM), .IW(LW)) u_pick_next (
        .i_vec    (w_remain),
        .o_idx    (w_next_idx),
        .o_onehot (w_next_oh),
        .o_any    (w_next_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_done_q   <= '0;
            r_lane_q   <= '0;
            r_lane_oh  <= '0;
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
            for (int i = 0; i < ISSUE_NUM; i++) begin
                r_res_q[i] <= '0;
            end
        end else if (flush) begin
            // Flush kills the bundle from any state; a coincident md_done is dropped.
            r_state    <= IDLE;
            r_pending  <= '0;
            r_done_q   <= '0;
            r_wdog_cnt <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req_any) begin
                        r_pending <= w_req_vec;
                        r_lane_q  <= w_req_idx;
                        r_lane_oh <= w_req_oh;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_wdog_cnt <= '0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (r_wdog_cnt != CW'(MAX_LAT)) begin
                        r_wdog_cnt <= r_wdog_cnt + 1'b1;
                    end
                    // Flag rises together with the counter reaching MAX_LAT; FSM keeps waiting.
                    if (r_wdog_cnt == CW'(MAX_LAT - 1)) begin
                        r_wdog_err <= 1'b1;
                    end
                    if (md_done) begin
                        r_res_q[r_lane_q] <= md_res;
                        r_done_q          <= r_done_q | r_lane_oh;
                        r_pending         <= w_remain;
                        if (w_next_any) begin
                            r_lane_q  <= w_next_idx;
                            r_lane_oh <= w_next_oh;
                            r_state   <= ISSUE;
                        end else begin
                            r_state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    r_done_q <= '0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_busy    = (r_state == ISSUE) || (r_state == WAIT);
    assign md_start  = (r_state == ISSUE);
    assign md_abort  = flush & w_busy;
    assign md_op     = w_busy ? w_lane[r_lane_q].op     : 3'd0;
    assign md_word32 = w_busy ? w_lane[r_lane_q].word32 : 1'b0;
    assign md_a      = w_busy ? w_lane[r_lane_q].a      : '0;
    assign md_b      = w_busy ? w_lane[r_lane_q].b      : '0;
    assign stall     = ((r_state == IDLE) & w_req_any & ~flush) | w_busy;
    assign res_valid = (r_state == HOLD) ? r_done_q : '0;
    assign wdog_err  = r_wdog_err;

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: a behavioural mul/div unit answers start pulses after a
// programmable latency; retired bundles are checked against a result queue.
module tb_md_sched;
    import md_sched_pkg::*;

    localparam int NL      = 2;
    localparam int MAX_LAT = 80;

    logic              clk;
    logic              rst;
    logic              flush;
    logic [NL-1:0]     req_valid;
    logic [NL*3-1:0]   req_op;
    logic [NL-1:0]     req_word32;
    logic [NL*64-1:0]  req_a;
    logic [NL*64-1:0]  req_b;
    logic              md_start;
    logic [2:0]        md_op;
    logic              md_word32;
    logic [63:0]       md_a;
    logic [63:0]       md_b;
    logic              md_abort;
    logic              md_done;
    logic [63:0]       md_res;
    logic              stall;
    logic [NL-1:0]     res_valid;
    logic [NL*64-1:0]  res;
    logic              wdog_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  mask;
        logic [63:0] r0;
        logic [63:0] r1;
    } exp_t;
    exp_t sb_q[$];

    int          unit_lat  = 1;
    bit          unit_mute = 1'b0;
    bit          inj_done  = 1'b0;
    int          unit_cnt  = 0;
    logic [63:0] unit_res  = '0;

    md_sched #(.ISSUE_NUM(NL), .MAX_LAT(MAX_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_word32 (req_word32),
        .req_a      (req_a),
        .req_b      (req_b),
        .md_start   (md_start),
        .md_op      (md_op),
        .md_word32  (md_word32),
        .md_a       (md_a),
        .md_b       (md_b),
        .md_abort   (md_abort),
        .md_done    (md_done),
        .md_res     (md_res),
        .stall      (stall),
        .res_valid  (res_valid),
        .res        (res),
        .wdog_err   (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = '0;
        case (op)
            3'd0: return a * b;
            3'd1: begin p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return p[127:64]; end
            3'd2: begin p = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); return p[127:64]; end
            3'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
            3'd4: return (b == 64'd0) ? '1 : 64'($signed(a) / $signed(b));
            3'd5: return (b == 64'd0) ? '1 : a / b;
            3'd6: return (b == 64'd0) ? a : 64'($signed(a) % $signed(b));
            default: return (b == 64'd0) ? a : a % b;
        endcase
    endfunction

    // Behavioural shared unit: done arrives unit_lat cycles after the start cycle.
    initial begin
        md_done = 1'b0;
        md_res  = '0;
        forever begin
            @(negedge clk);
            if (md_abort) begin
                unit_cnt = 0;
            end else if (md_start) begin
                unit_cnt = unit_lat;
                unit_res = ref_md(md_op, md_a, md_b);
            end
            @(posedge clk);
            #1;
            md_done = 1'b0;
            if (inj_done) begin
                md_done  = 1'b1;
                md_res   = 64'hDEAD_BEEF_0BAD_F00D;
                inj_done = 1'b0;
            end else if (unit_cnt > 0) begin
                unit_cnt--;
                if (unit_cnt == 0 && !unit_mute) begin
                    md_done = 1'b1;
                    md_res  = unit_res;
                end
            end
        end
    end

    // Retirement monitor: every res_valid must match the oldest queued bundle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (res_valid !== 2'b00) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected res_valid=%b required=00", res_valid);
                end else begin
                    e = sb_q.pop_front();
                    if (res_valid !== e.mask) begin
                        failures++;
                        $display("FAIL sb_mask res_valid=%b required=%b", res_valid, e.mask);
                    end
                    if (e.mask[0]) begin
                        checks++;
                        if (res[63:0] !== e.r0) begin
                            failures++;
                            $display("FAIL sb_res0 res0=%0d required=%0d", res[63:0], e.r0);
                        end
                    end
                    if (e.mask[1]) begin
                        checks++;
                        if (res[127:64] !== e.r1) begin
                            failures++;
                            $display("FAIL sb_res1 res1=%0d required=%0d", res[127:64], e.r1);
                        end
                    end
                    $display("retire mask=%b res0=%0d res1=%0d", res_valid, res[63:0], res[127:64]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [2:0] op0, input logic [2:0] op1,
                           input logic [1:0] w32, input logic [63:0] a0, input logic [63:0] b0,
                           input logic [63:0] a1, input logic [63:0] b1);
        req_valid  = v;
        req_op     = {op1, op0};
        req_word32 = w32;
        req_a      = {a1, a0};
        req_b      = {b1, b0};
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || md_start !== 1'b0 || md_abort !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl stall=%b start=%b abort=%b required=000", stall, md_start, md_abort);
        end
        checks++;
        if (res_valid !== 2'b00 || res !== '0 || wdog_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_res res_valid=%b res=%h wdog=%b required=0", res_valid, res, wdog_err);
        end
        checks++;
        if (md_a !== 64'd0 || md_b !== 64'd0 || md_op !== 3'd0) begin
            failures++;
            $display("FAIL reset_md md_a=%0d md_b=%0d md_op=%0d required=0", md_a, md_b, md_op);
        end
        $display("reset checked");
        next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_single();
        unit_lat = 5;
        for (int c = 0; c <= 8; c++) begin
            next_cycle();
            if (c == 0) begin
                set_req(2'b01, MD_DIV, MD_MUL, 2'b00, 64'd100, 64'd7, 64'd0, 64'd0);
                sb_q.push_back('{2'b01, 64'd14, 64'd0});
            end
            if (c == 8) set_req(2'b00, MD_MUL, MD_MUL, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
            @(negedge clk);
            checks++;
            if (stall !== (c <= 6)) begin
                failures++;
                $display("FAIL single_stall cycle=%0d stall=%b required=%b", c, stall, (c <= 6));
            end
            checks++;
            if (md_start !== (c == 1)) begin
                failures++;
                $display("FAIL single_start cycle=%0d md_start=%b required=%b", c, md_start, (c == 1));
            end
            if (c == 1) begin
                checks++;
                if (md_a !== 64'd100 || md_b !== 64'd7 || md_op !== 3'(MD_DIV)) begin
                    failures++;
                    $display("FAIL single_ops md_a=%0d md_b=%0d op=%0d required=100 7 4", md_a, md_b, md_op);
                end
            end
        end
        $display("single lane0 DIV done");
    endtask

    task automatic test_dual();
        unit_lat = 3;
        for (int c = 0; c <= 10; c++) begin
            next_cycle();
            if (c == 0) begin
                set_req(2'b11, MD_MUL, MD_REMU, 2'b00, 64'd3, 64'd4, 64'd10, 64'd3);
                sb_q.push_back('{2'b11, 64'd12, 64'd1});
            end
            if (c == 10) set_req(2'b00, MD_MUL, MD_MUL, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
            @(negedge clk);
            checks++;
            if (stall !== (c <= 8)) begin
                failures++;
                $display("FAIL dual_stall cycle=%0d stall=%b required=%b", c, stall, (c <= 8));
            end
            checks++;
            if (md_start !== (c == 1 || c == 5)) begin
                failures++;
                $display("FAIL dual_start cycle=%0d md_start=%b required=%b", c, md_start, (c == 1 || c == 5));
            end
            if (c == 1) begin
                checks++;
                if (md_a !== 64'd3 || md_b !== 64'd4 || md_op !== 3'(MD_MUL)) begin
                    failures++;
                    $display("FAIL dual_ops0 md_a=%0d md_b=%0d op=%0d required=3 4 0", md_a, md_b, md_op);
                end
            end
            if (c == 5) begin
                checks++;
                if (md_a !== 64'd10 || md_b !== 64'd3 || md_op !== 3'(MD_REMU)) begin
                    failures++;
                    $display("FAIL dual_ops1 md_a=%0d md_b=%0d op=%0d required=10 3 7", md_a, md_b, md_op);
                end
            end
        end
        $display("dual MUL+REMU done");
    endtask

    task automatic test_lane1();
        unit_lat = 2;
        for (int c = 0; c <= 5; c++) begin
            next_cycle();
            if (c == 0) begin
                set_req(2'b10, MD_MUL, MD_MULHU, 2'b10, 64'd55, 64'd66, 64'h8000_0000_0000_0000, 64'd4);
                sb_q.push_back('{2'b10, 64'd0, 64'd2});
            end
            if (c == 5) set_req(2'b00, MD_MUL, MD_MUL, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
            @(negedge clk);
            checks++;
            if (stall !== (c <= 3)) begin
                failures++;
                $display("FAIL lane1_stall cycle=%0d stall=%b required=%b", c, stall, (c <= 3));
            end
            checks++;
            if (md_start !== (c == 1)) begin
                failures++;
                $display("FAIL lane1_start cycle=%0d md_start=%b required=%b", c, md_start, (c == 1));
            end
            if (c == 1) begin
                checks++;
                if (md_a !== 64'h8000_0000_0000_0000 || md_b !== 64'd4 || md_op !== 3'(MD_MULHU) || md_word32 !== 1'b1) begin
                    failures++;
                    $display("FAIL lane1_ops md_a=%h md_b=%0d op=%0d w32=%b required=8000000000000000 4 3 1",
                             md_a, md_b, md_op, md_word32);
                end
            end
        end
        $display("lane1 MULHU done");
    endtask

    task automatic test_flush_wait();
        unit_lat = 5;
        for (int c = 0; c <= 7; c++) begin
            next_cycle();
            if (c == 0) set_req(2'b01, MD_MUL, MD_MUL, 2'b00, 64'd5, 64'd6, 64'd0, 64'd0);
            if (c == 3) flush = 1'b1;
            if (c == 4) begin
                flush = 1'b0;
                set_req(2'b00, MD_MUL, MD_MUL, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
            end
            @(negedge clk);
            checks++;
            if (md_abort !== (c == 3)) begin
                failures++;
                $display("FAIL flushw_abort cycle=%0d md_abort=%b required=%b", c, md_abort, (c == 3));
            end
            checks++;
            if (stall !== (c <= 3)) begin
                failures++;
                $display("FAIL flushw_stall cycle=%0d stall=%b required=%b", c, stall, (c <= 3));
            end
            if (c >= 4) begin
                checks++;
                if (md_start !== 1'b0 || res_valid !== 2'b00) begin
                    failures++;
                    $display("FAIL flushw_idle cycle=%0d md_start=%b res_valid=%b required=0 00", c, md_start, res_valid);
                end
            end
            if (c == 3) inj_done = 1'b1;
        end
        $display("flush in WAIT with late done done");
    endtask

    task automatic test_done_flush();
        unit_lat = 2;
        for (int c = 0; c <= 8; c++) begin
            next_cycle();
            if (c == 0) set_req(2'b11, MD_DIVU, MD_MUL, 2'b00, 64'd9, 64'd3, 64'd2, 64'd2);
            if (c == 3) flush = 1'b1;
            if (c == 4) begin
                flush = 1'b0;
                set_req(2'b00, MD_MUL, MD_MUL, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
            end
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if (md_done !== 1'b1 || md_abort !== 1'b1) begin
                    failures++;
                    $display("FAIL dflush_coincide md_done=%b md_abort=%b required=1 1", md_done, md_abort);
                end
            end
            checks++;
            if (md_start !== (c == 1)) begin
                failures++;
                $display("FAIL dflush_start cycle=%0d md_start=%b required=%b", c, md_start, (c == 1));
            end
            if (c >= 4) begin
                checks++;
                if (stall !== 1'b0 || res_valid !== 2'b00) begin
                    failures++;
                    $display("FAIL dflush_idle cycle=%0d stall=%b res_valid=%b required=0 00", c, stall, res_valid);
                end
            end
        end
        $display("done+flush coincide done");
    endtask

    task automatic test_wdog();
        unit_mute = 1'b1;
        unit_lat  = 2;
        for (int c = 0; c <= MAX_LAT + 3; c++) begin
            next_cycle();
            if (c == 0) set_req(2'b01, MD_DIVU, MD_MUL, 2'b00, 64'd50, 64'd5, 64'd0, 64'd0);
            @(negedge clk);
            checks++;
            if (wdog_err !== (c >= MAX_LAT + 2)) begin
                failures++;
                $display("FAIL wdog_err cycle=%0d wdog_err=%b required=%b", c, wdog_err, (c >= MAX_LAT + 2));
            end
            if (c >= MAX_LAT) begin
                checks++;
                if (stall !== 1'b1) begin
                    failures++;
                    $display("FAIL wdog_stall cycle=%0d stall=%b required=1", c, stall);
                end
            end
        end
        #2;
        rst = 1'b0;
        set_req(2'b00, MD_MUL, MD_MUL, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
        #1;
        checks++;
        if (wdog_err !== 1'b0 || stall !== 1'b0 || md_start !== 1'b0 || md_a !== 64'd0) begin
            failures++;
            $display("FAIL async_reset wdog=%b stall=%b start=%b md_a=%0d required=0 0 0 0",
                     wdog_err, stall, md_start, md_a);
        end
        checks++;
        if (res_valid !== 2'b00 || res !== '0) begin
            failures++;
            $display("FAIL async_reset_res res_valid=%b res=%h required=0", res_valid, res);
        end
        unit_mute = 1'b0;
        next_cycle();
        rst = 1'b1;
        $display("watchdog and async reset done");
    endtask

    task automatic test_after_reset();
        unit_lat = 1;
        for (int c = 0; c <= 4; c++) begin
            next_cycle();
            if (c == 0) begin
                set_req(2'b01, MD_DIVU, MD_MUL, 2'b00, 64'd50, 64'd5, 64'd0, 64'd0);
                sb_q.push_back('{2'b01, 64'd10, 64'd0});
            end
            if (c == 4) set_req(2'b00, MD_MUL, MD_MUL, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
            @(negedge clk);
            checks++;
            if (stall !== (c <= 2)) begin
                failures++;
                $display("FAIL post_stall cycle=%0d stall=%b required=%b", c, stall, (c <= 2));
            end
        end
        $display("post-reset DIVU done");
    endtask

    initial begin
        rst   = 1'b0;
        flush = 1'b0;
        set_req(2'b00, MD_MUL, MD_MUL, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
        test_reset();
        test_single();
        test_dual();
        test_lane1();
        test_flush_wait();
        test_done_flush();
        test_wdog();
        test_after_reset();
        next_cycle();
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
